regfile32: RTL and testbench
============================

REGFILE32 -- requirements
Module: regfile32

Interface
REQ-001 Parameter DATA_W, default 32, register data width in bits.
REQ-002 Parameter ADDR_W, default 5, register address width; depth is 2**ADDR_W (32).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 we  input  1  write enable, sampled on rising clk.
REQ-007 waddr  input  ADDR_W  write destination address (rd/rt selected upstream).
REQ-008 wdata  input  DATA_W  write data.
REQ-009 raddr1  input  ADDR_W  read port 1 address (rs).
REQ-010 raddr2  input  ADDR_W  read port 2 address (rt).
REQ-011 rdata1  output  DATA_W  read port 1 data.
REQ-012 rdata2  output  DATA_W  read port 2 data.
REQ-013 wr_cnt  output  16  count of committed writes, for debug and bench use.

Function
REQ-014 The block SHALL hold 32 registers of DATA_W bits; register 0 SHALL read as zero at all times.
REQ-015 A write SHALL commit on the rising clk edge when we=1 and waddr!=0.
REQ-016 A committed write SHALL store wdata at waddr; the new value is visible in the array from the next cycle.
REQ-017 A write with waddr=0 SHALL be discarded and SHALL NOT increment wr_cnt.
REQ-018 Reads SHALL be combinational, with zero-cycle latency from raddrN to rdataN.
REQ-019 Same-cycle bypass: if we=1, waddr!=0 and raddrN==waddr, rdataN SHALL equal wdata; otherwise it SHALL equal the array content.
REQ-020 raddrN=0 SHALL return 0, including when we=1 and waddr=0 with nonzero wdata.
REQ-021 Both read ports SHALL be independent; both may address the same register, and both SHALL bypass simultaneously.
REQ-022 wr_cnt SHALL increment by 1 on each committed write and SHALL wrap from 0xFFFF to 0x0000.
REQ-023 X or Z on waddr or wdata while we=0 SHALL NOT alter state.

Reset
REQ-024 When rst_n=0, all 31 writable registers and wr_cnt SHALL clear to 0 immediately, without waiting for clk.
REQ-025 While rst_n=0, writes SHALL be ignored and bypass SHALL be suppressed, so rdata1 = rdata2 = 0.
REQ-026 Reset assertion mid-operation SHALL take priority over a coincident write edge; no partial write survives.
REQ-027 After deassertion, the first rising clk edge with we=1 SHALL commit normally.

Structure
REQ-028 A shared package SHALL hold DATA_W, ADDR_W, REG_ZERO (5'd0) and reset-value constants, shared with the datapath and write-address select logic.
REQ-029 One sub-module, regfile_bypass, SHALL implement the per-port compare and select; it SHALL be instantiated twice.
REQ-030 Storage SHALL be flip-flops, not inferred RAM, so that asynchronous clear is possible.

Verification
REQ-031 Reset and read-all: pulse rst_n low, then read all 32 addresses -> every rdata = 0 and wr_cnt = 0.
REQ-032 Basic write/read: write 0xDEADBEEF to reg 8, then the next cycle raddr1=8 -> rdata1 = 0xDEADBEEF and wr_cnt = 1.
REQ-033 Bypass: we=1, waddr=9, wdata=0x12345678, raddr1=raddr2=9 in the same cycle -> both rdata = 0x12345678 before the edge.
REQ-034 Zero register: write 0xFFFFFFFF to reg 0, then raddr1=0 -> rdata1 = 0 and wr_cnt unchanged.
REQ-035 Async reset mid-write: assert rst_n low 2 ns before an edge with we=1, waddr=3, wdata=0xA5A5A5A5 -> reg 3 = 0 after release.
REQ-036 Counter wrap: preload by performing 65536 writes -> wr_cnt returns to 0x0000, and register contents match the last written data.

Source files
------------

// File: rtl/regfile32_pkg.sv
// Shared constants for the 32-entry register file: widths, the hardwired-zero
// register address and the reset values of storage and the write counter.
`timescale 1ns/1ps
package regfile32_pkg;
  localparam int              DATA_W   = 32;
  localparam int              ADDR_W   = 5;
  localparam int              CNT_W    = 16;
  localparam logic [4:0]      REG_ZERO = 5'd0;
  localparam logic [31:0]     RST_DATA = 32'd0;
  localparam logic [CNT_W-1:0] RST_CNT = '0;
endpackage

// File: rtl/regfile32_if.sv
// Write/read bus of the register file; the master drives addresses and write
// data, the slave returns both read ports and the committed-write count.
`timescale 1ns/1ps
interface regfile32_if #(
  parameter int DATA_W = regfile32_pkg::DATA_W,
  parameter int ADDR_W = regfile32_pkg::ADDR_W,
  parameter int CNT_W  = regfile32_pkg::CNT_W
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic [CNT_W-1:0]  wr_cnt;

  modport master (output we, waddr, wdata, raddr1, raddr2,
                  input  rdata1, rdata2, wr_cnt);
  modport slave  (input  we, waddr, wdata, raddr1, raddr2,
                  output rdata1, rdata2, wr_cnt);
endinterface

// File: rtl/regfile_bypass.sv
// One read port: forces zero for register 0 and during reset, and forwards the
// in-flight write data when it targets the address being read.
`timescale 1ns/1ps
module regfile_bypass #(
  parameter int DATA_W = regfile32_pkg::DATA_W,
  parameter int ADDR_W = regfile32_pkg::ADDR_W
) (
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  input  logic [DATA_W-1:0] arr_i,
  output logic [DATA_W-1:0] rdata_o
);
  import regfile32_pkg::*;

  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);
  localparam logic [DATA_W-1:0] ZERO_D = DATA_W'(RST_DATA);

  always_comb begin
    rdata_o = ZERO_D;
    if (rst_n && (raddr_i != ZERO_A)) begin
      if (we_i && (waddr_i != ZERO_A) && (raddr_i == waddr_i))
        rdata_o = wdata_i;
      else
        rdata_o = arr_i;
    end
  end
endmodule

// File: rtl/regfile32.sv
// 32 x DATA_W flip-flop register file, register 0 hardwired to zero, two
// combinational read ports with same-cycle write bypass, and a write counter.
`timescale 1ns/1ps
module regfile32 #(
  parameter int DATA_W = regfile32_pkg::DATA_W,
  parameter int ADDR_W = regfile32_pkg::ADDR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile32_if.slave   bus
);
  import regfile32_pkg::*;

  localparam int NREG = 2**ADDR_W;
  localparam int NRD  = 2;

  logic [NREG-1:0][DATA_W-1:0] regs_q;
  logic [CNT_W-1:0]            wr_cnt_q, wr_cnt_d;
  logic                        commit;

  logic [NRD-1:0][ADDR_W-1:0]  raddr_a;
  logic [NRD-1:0][DATA_W-1:0]  arr_a;
  logic [NRD-1:0][DATA_W-1:0]  rdata_a;

  // Gate on we first so an undriven address with we=0 cannot commit.
  assign commit   = bus.we && (bus.waddr != ADDR_W'(REG_ZERO));
  assign wr_cnt_d = wr_cnt_q + CNT_W'(1);

  // Flops, not RAM: the whole array must clear asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q   <= '0;
      wr_cnt_q <= RST_CNT;
    end else if (commit) begin
      regs_q[bus.waddr] <= bus.wdata;
      wr_cnt_q          <= wr_cnt_d;
    end
  end

  assign raddr_a[0] = bus.raddr1;
  assign raddr_a[1] = bus.raddr2;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    assign arr_a[p] = regs_q[raddr_a[p]];
  end

  regfile_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_byp [NRD-1:0] (
    .rst_n   (rst_n),
    .we_i    (bus.we),
    .waddr_i (bus.waddr),
    .wdata_i (bus.wdata),
    .raddr_i (raddr_a),
    .arr_i   (arr_a),
    .rdata_o (rdata_a)
  );

  assign bus.rdata1 = rdata_a[0];
  assign bus.rdata2 = rdata_a[1];
  assign bus.wr_cnt = wr_cnt_q;
endmodule

// File: tb/tb_regfile32.sv
// Randomized and directed checks of regfile32 against an array-based model of
// the architectural register state and committed-write count.
`timescale 1ns/1ps
module tb_regfile32;
  logic clk;
  logic rst_n;

  regfile32_if bus ();

  regfile32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  logic [31:0] mdl [32];
  int unsigned cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    cnt = 0;
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] ra, input logic w,
                                         input logic [4:0] wa, input logic [31:0] wd);
    if (ra == 5'd0) return 32'd0;
    if (w === 1'b1 && wa != 5'd0 && ra == wa) return wd;
    return mdl[ra];
  endfunction

  // Called just after a rising edge: apply inputs, check reads mid-cycle,
  // then let the edge happen and update the model.
  task automatic cycle(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2);
    bus.we = w; bus.waddr = wa; bus.wdata = wd; bus.raddr1 = r1; bus.raddr2 = r2;
    @(negedge clk);
    chk("rdata1", bus.rdata1, exp_rd(r1, w, wa, wd));
    chk("rdata2", bus.rdata2, exp_rd(r2, w, wa, wd));
    chk("wr_cnt", {16'd0, bus.wr_cnt}, cnt & 32'hFFFF);
    @(posedge clk);
    if (w === 1'b1 && wa != 5'd0) begin
      mdl[wa] = wd;
      cnt++;
    end
    #1;
  endtask

  task automatic read_all();
    for (int a = 0; a < 32; a++) cycle(1'b0, 5'd0, 32'd0, 5'(a), 5'(31 - a));
  endtask

  initial begin
    logic [4:0]  wa, r1, r2;
    logic [31:0] wd;
    logic        w;

    rst_n = 1'b0;
    bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0; bus.raddr1 = '0; bus.raddr2 = '0;
    mdl_clear();

    // Write and bypass attempt while held in reset must read as zero.
    @(posedge clk); #1;
    bus.we = 1'b1; bus.waddr = 5'd5; bus.wdata = 32'hCAFEF00D;
    bus.raddr1 = 5'd5; bus.raddr2 = 5'd5;
    #2;
    chk("rst_byp1", bus.rdata1, 32'd0);
    chk("rst_byp2", bus.rdata2, 32'd0);
    @(posedge clk); #1;
    bus.we = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    read_all();
    chk("rst_cnt", {16'd0, bus.wr_cnt}, 32'd0);

    // Basic write then read next cycle.
    cycle(1'b1, 5'd8, 32'hDEADBEEF, 5'd0, 5'd1);
    cycle(1'b0, 5'd0, 32'd0, 5'd8, 5'd8);
    chk("wr8_data", bus.rdata1, 32'hDEADBEEF);
    chk("wr8_cnt", {16'd0, bus.wr_cnt}, 32'd1);

    // Same-cycle bypass on both ports.
    cycle(1'b1, 5'd9, 32'h12345678, 5'd9, 5'd9);

    // Writes to register 0 are dropped; bypass suppressed for raddr 0.
    cycle(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    cycle(1'b0, 5'd0, 32'd0, 5'd0, 5'd9);
    chk("zero_cnt", {16'd0, bus.wr_cnt}, 32'd2);

    // Undriven address/data with we=0 must not change state.
    cycle(1'b0, 5'bx, 32'bx, 5'd8, 5'd9);

    // Asynchronous reset 2 ns before an edge carrying a write to reg 3.
    cycle(1'b1, 5'd3, 32'h11111111, 5'd0, 5'd0);
    cycle(1'b0, 5'd0, 32'd0, 5'd3, 5'd3);
    bus.we = 1'b1; bus.waddr = 5'd3; bus.wdata = 32'hA5A5A5A5;
    bus.raddr1 = 5'd3; bus.raddr2 = 5'd8;
    #7;
    rst_n = 1'b0;
    #1;
    chk("arst_rd1", bus.rdata1, 32'd0);
    chk("arst_rd2", bus.rdata2, 32'd0);
    chk("arst_cnt", {16'd0, bus.wr_cnt}, 32'd0);
    mdl_clear();
    @(posedge clk); #1;
    bus.we = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    cycle(1'b0, 5'd0, 32'd0, 5'd3, 5'd8);
    chk("arst_reg3", bus.rdata1, 32'd0);

    // First write after release commits.
    cycle(1'b1, 5'd4, 32'h0BADCAFE, 5'd1, 5'd2);
    cycle(1'b0, 5'd0, 32'd0, 5'd4, 5'd3);
    chk("post_rst_wr", bus.rdata1, 32'h0BADCAFE);

    // Random traffic with address collisions favoured.
    for (int i = 0; i < 400; i++) begin
      w  = 1'($urandom_range(0, 1));
      wa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      wd = $urandom;
      r1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      cycle(w, wa, wd, r1, r2);
    end
    read_all();

    // Counter wrap: 65536 committed writes from a fresh reset.
    rst_n = 1'b0;
    #2;
    mdl_clear();
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 65536; i++) begin
      bus.we = 1'b1;
      bus.waddr = 5'(1 + (i % 31));
      bus.wdata = $urandom;
      if (i == 65535) begin
        #1;
        chk("cnt_ffff", {16'd0, bus.wr_cnt}, 32'h0000FFFF);
      end
      @(posedge clk);
      mdl[bus.waddr] = bus.wdata;
      cnt++;
      #1;
    end
    bus.we = 1'b0;
    chk("cnt_wrap", {16'd0, bus.wr_cnt}, 32'd0);
    read_all();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
